// File: rtl/pc_next_select_reg.sv
// ============================================================================
// Module   : pc_next_select_reg
// Purpose  : Fixed-priority next-PC select with registered fetch PC. Holds the
//            PC on stall and defers a redirect seen during a stall until
//            release. Optional macro PC_REDIRECT_COUNT_EN adds redirectCount.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_select_reg #(
    parameter int               WIDTH    = 10,
    parameter int               NUM_SRC  = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    localparam int              IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*WIDTH-1:0] srcValues,
    input  logic [NUM_SRC-1:0]       srcValid,
    input  logic                     stall,
    output logic [WIDTH-1:0]         pcOut,
    output logic [IDX_W-1:0]         selIndex,
    output logic                     redirectTaken,
`ifdef PC_REDIRECT_COUNT_EN
    output logic [15:0]              redirectCount,
`endif
    output logic                     pendingValid
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             redir_q, redir_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;

    logic [WIDTH-1:0] src_arr [NUM_SRC];
    logic [IDX_W-1:0] win_idx;
    logic [WIDTH-1:0] win_val;
    logic             fresh;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_arr[g] = srcValues[g*WIDTH +: WIDTH];
    end

    // Ascending scan: the highest valid index k>=1 is the last one written.
    always_comb begin
        win_idx = '0;
        for (int k = 1; k < NUM_SRC; k++) begin
            if (srcValid[k]) begin
                win_idx = IDX_W'(k);
            end
        end
    end

    assign win_val = src_arr[win_idx];
    assign fresh   = (win_idx != '0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        sel_d      = sel_q;
        redir_d    = 1'b0;
        pend_tgt_d = pend_tgt_q;
        pend_idx_d = pend_idx_q;

        if (!stall) begin
            if (fresh) begin
                pc_d    = win_val;
                sel_d   = win_idx;
                redir_d = 1'b1;
                state_d = ST_IDLE;
            end else if (state_q == ST_PEND) begin
                pc_d    = pend_tgt_q;
                sel_d   = pend_idx_q;
                redir_d = 1'b1;
                state_d = ST_IDLE;
            end else begin
                pc_d    = src_arr[0];
                sel_d   = '0;
            end
        end else if (fresh) begin
            // Last redirect within a stall replaces any earlier capture.
            pend_tgt_d = win_val;
            pend_idx_d = win_idx;
            state_d    = ST_PEND;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            sel_q      <= '0;
            redir_q    <= 1'b0;
            pend_tgt_q <= '0;
            pend_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            sel_q      <= sel_d;
            redir_q    <= redir_d;
            pend_tgt_q <= pend_tgt_d;
            pend_idx_q <= pend_idx_d;
        end
    end

`ifdef PC_REDIRECT_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (redir_d && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign redirectCount = cnt_q;
`endif

    assign pcOut         = pc_q;
    assign selIndex      = sel_q;
    assign redirectTaken = redir_q;
    assign pendingValid  = (state_q == ST_PEND);

endmodule

`default_nettype wire

// File: tb/tb_pc_next_select_reg.sv
// ============================================================================
// Module   : tb_pc_next_select_reg
// Purpose  : Directed vector bench for pc_next_select_reg (optional
//            PC_REDIRECT_COUNT_EN checks included when the macro is set).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_next_select_reg;

    localparam int WIDTH   = 10;
    localparam int NUM_SRC = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic [NUM_SRC*WIDTH-1:0] srcValues = '0;
    logic [NUM_SRC-1:0]       srcValid = '0;
    logic                     stall = 1'b0;
    logic [WIDTH-1:0]         pcOut;
    logic [1:0]               selIndex;
    logic                     redirectTaken;
    logic                     pendingValid;
`ifdef PC_REDIRECT_COUNT_EN
    logic [15:0]              redirectCount;
`endif

    int checks = 0;
    int errors = 0;

    pc_next_select_reg #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .RESET_PC(10'h000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .srcValues    (srcValues),
        .srcValid     (srcValid),
        .stall        (stall),
        .pcOut        (pcOut),
        .selIndex     (selIndex),
        .redirectTaken(redirectTaken),
`ifdef PC_REDIRECT_COUNT_EN
        .redirectCount(redirectCount),
`endif
        .pendingValid (pendingValid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stall;
        logic [3:0] valid;
        logic [9:0] s0, s1, s2, s3;
        logic [9:0] pc;
        logic [1:0] sel;
        logic       redir;
        logic       pend;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [3:0] v,
                         input logic [9:0] s0, input logic [9:0] s1,
                         input logic [9:0] s2, input logic [9:0] s3);
        stall     = st;
        srcValid  = v;
        srcValues = {s3, s2, s1, s0};
    endtask

    initial begin
        //             stall valid    s0      s1      s2      s3      pc     sel r  p
        vecs[0]  = '{1'b0, 4'b0000, 10'h001, 10'h000, 10'h000, 10'h000, 10'h001, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0110, 10'h002, 10'h040, 10'h080, 10'h000, 10'h080, 2'd2, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 10'h005, 10'h040, 10'h080, 10'h000, 10'h005, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'b1000, 10'h006, 10'h000, 10'h000, 10'h123, 10'h005, 2'd0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 4'b0000, 10'h006, 10'h000, 10'h000, 10'h000, 10'h005, 2'd0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 4'b0000, 10'h006, 10'h000, 10'h000, 10'h000, 10'h005, 2'd0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 4'b0000, 10'h006, 10'h000, 10'h000, 10'h000, 10'h005, 2'd0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 4'b0000, 10'h006, 10'h000, 10'h000, 10'h000, 10'h123, 2'd3, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'b0000, 10'h124, 10'h000, 10'h000, 10'h000, 10'h124, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'b0100, 10'h125, 10'h000, 10'h0AA, 10'h000, 10'h124, 2'd0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 4'b0010, 10'h125, 10'h0BB, 10'h000, 10'h000, 10'h124, 2'd0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 4'b0000, 10'h125, 10'h000, 10'h000, 10'h000, 10'h0BB, 2'd1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 4'b0001, 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h0BB, 2'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 4'b1111, 10'h011, 10'h022, 10'h033, 10'h3FE, 10'h3FE, 2'd3, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 4'b1000, 10'h011, 10'h000, 10'h000, 10'h123, 10'h3FE, 2'd3, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 4'b0010, 10'h011, 10'h200, 10'h000, 10'h000, 10'h200, 2'd1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 4'b0000, 10'h201, 10'h000, 10'h000, 10'h000, 10'h201, 2'd0, 1'b0, 1'b0};

        // Asynchronous reset asserted mid-cycle, checked before any edge.
        #3 rst_n = 1'b0;
        #1;
        check("reset_pc",    32'(pcOut), 32'h000);
        check("reset_sel",   32'(selIndex), 32'd0);
        check("reset_redir", 32'(redirectTaken), 32'd0);
        check("reset_pend",  32'(pendingValid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].stall, vecs[i].valid, vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pc", i),    32'(pcOut), 32'(vecs[i].pc));
            check($sformatf("v%0d_sel", i),   32'(selIndex), 32'(vecs[i].sel));
            check($sformatf("v%0d_redir", i), 32'(redirectTaken), 32'(vecs[i].redir));
            check($sformatf("v%0d_pend", i),  32'(pendingValid), 32'(vecs[i].pend));
        end

`ifdef PC_REDIRECT_COUNT_EN
        check("count_after_table", 32'(redirectCount), 32'd5);
`endif

        // Reset while a redirect is pending: the pending target must be lost.
        @(negedge clk);
        drive(1'b1, 4'b0100, 10'h201, 10'h000, 10'h155, 10'h000);
        @(posedge clk);
        #1;
        check("midpend_set", 32'(pendingValid), 32'd1);
        @(negedge clk);
        drive(1'b1, 4'b0000, 10'h201, 10'h000, 10'h000, 10'h000);
        #2 rst_n = 1'b0;
        #1;
        check("midpend_rst_pc",   32'(pcOut), 32'h000);
        check("midpend_rst_pend", 32'(pendingValid), 32'd0);
`ifdef PC_REDIRECT_COUNT_EN
        check("midpend_rst_count", 32'(redirectCount), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'b0000, 10'h010, 10'h000, 10'h000, 10'h000);
        @(posedge clk);
        #1;
        check("post_rst_pc",    32'(pcOut), 32'h010);
        check("post_rst_sel",   32'(selIndex), 32'd0);
        check("post_rst_redir", 32'(redirectTaken), 32'd0);
        @(negedge clk);
        drive(1'b0, 4'b0000, 10'h011, 10'h000, 10'h000, 10'h000);
        @(posedge clk);
        #1;
        check("post_rst_pc2",   32'(pcOut), 32'h011);
        check("post_rst_redir2", 32'(redirectTaken), 32'd0);

`ifdef PC_REDIRECT_COUNT_EN
        // Drive the counter to saturation, then one more redirect.
        @(negedge clk);
        drive(1'b0, 4'b0010, 10'h000, 10'h050, 10'h000, 10'h000);
        repeat (65535) @(posedge clk);
        #1;
        check("count_full", 32'(redirectCount), 32'hFFFF);
        @(posedge clk);
        #1;
        check("count_sat", 32'(redirectCount), 32'hFFFF);
        check("count_sat_redir", 32'(redirectTaken), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
